// File: rtl/pipelined_addsub.sv
// pipelined_addsub -- pipelined ripple-carry adder/subtractor.
//
// WIDTH-bit operands are split into CHUNK-bit segments; each pipeline stage
// ripples one segment through a chain of full_adder cells and registers the
// carry out for the next stage. Upper operand chunks are skewed through
// registers so each stage sees its chunk in step with the incoming carry.
// Finished lower result chunks travel forward with the operation, so the
// whole sum emerges aligned after STAGES enabled cycles.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   en        pipeline advance enable (0 = stall, every register holds)
//   in_valid  operands present this cycle
//   sub       0 = add, 1 = subtract (travels with the operation)
//   a, b      WIDTH-bit operands
//   ci        carry-in (add) or borrow-in (subtract)
//   out_valid result present this cycle
//   sum       WIDTH-bit result
//   co        carry out of the MSB (subtract: 1 = no borrow)
//   ovf       signed two's-complement overflow

// Single-bit full adder cell, the building block of each segment.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module pipelined_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);
    // Guarded copy of CHUNK so the derived values stay computable even for
    // an illegal configuration; the check below stops elaboration anyway.
    localparam int SAFE_CHUNK = (CHUNK < 1) ? 1 : CHUNK;
    localparam int STAGES     = (WIDTH / SAFE_CHUNK < 1) ? 1 : WIDTH / SAFE_CHUNK;

    generate
        if ((CHUNK < 1) || ((WIDTH % SAFE_CHUNK) != 0)) begin : g_bad_cfg
            $error("pipelined_addsub: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    genvar k, j;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stg
            logic             v_in;
            logic             c_in;
            logic [WIDTH-1:0] a_in;
            logic [WIDTH-1:0] bx_in;
            logic [WIDTH-1:0] s_in;
            logic [CHUNK-1:0] chunk_s;
            logic [WIDTH-1:0] s_nxt;
            logic             v_q;
            logic             c_q;
            logic [WIDTH-1:0] s_q;

            if (k == 0) begin : g_head
                // Subtraction is a + ~b + ~ci: invert b and the carry-in once
                // here, after which every stage is a plain adder.
                assign v_in  = in_valid;
                assign a_in  = a;
                assign bx_in = b ^ {WIDTH{sub}};
                assign c_in  = ci ^ sub;
                assign s_in  = '0;
            end else begin : g_body
                assign v_in  = g_stg[k-1].v_q;
                assign a_in  = g_stg[k-1].g_skew.a_q;
                assign bx_in = g_stg[k-1].g_skew.bx_q;
                assign c_in  = g_stg[k-1].c_q;
                assign s_in  = g_stg[k-1].s_q;
            end

            for (j = 0; j < CHUNK; j++) begin : g_bit
                logic ci_b;
                logic s_b;
                logic co_b;

                if (j == 0) begin : g_cin
                    assign ci_b = c_in;
                end else begin : g_cchain
                    assign ci_b = g_bit[j-1].co_b;
                end

                full_adder u_fa (
                    .a  (a_in[k*CHUNK + j]),
                    .b  (bx_in[k*CHUNK + j]),
                    .ci (ci_b),
                    .s  (s_b),
                    .co (co_b)
                );

                assign chunk_s[j] = s_b;
            end

            always_comb begin
                s_nxt = s_in;
                s_nxt[k*CHUNK +: CHUNK] = chunk_s;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    s_q <= '0;
                end else if (en) begin
                    v_q <= v_in;
                    c_q <= g_bit[CHUNK-1].co_b;
                    s_q <= s_nxt;
                end
            end

            if (k < STAGES - 1) begin : g_skew
                logic [WIDTH-1:0] a_q;
                logic [WIDTH-1:0] bx_q;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        a_q  <= '0;
                        bx_q <= '0;
                    end else if (en) begin
                        a_q  <= a_in;
                        bx_q <= bx_in;
                    end
                end
            end else begin : g_tail
                logic ovf_q;
                // Operands are fully consumed by the final segment.
                logic unused_skew;
                assign unused_skew = ^{a_in, bx_in};

                // Overflow: carry into the MSB differs from carry out of it.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        ovf_q <= 1'b0;
                    end else if (en) begin
                        ovf_q <= g_bit[CHUNK-1].ci_b ^ g_bit[CHUNK-1].co_b;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_stg[STAGES-1].v_q;
    assign sum       = g_stg[STAGES-1].s_q;
    assign co        = g_stg[STAGES-1].c_q;
    assign ovf       = g_stg[STAGES-1].g_tail.ovf_q;

endmodule
